// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Shares one single-port framebuffer RAM between VGA line fetches and a pixel writer.
// A line_start pulse starts a burst that reads H_PIX pixels of one line into the line buffer.
// Writer accesses use idle cycles. During a burst, a writer that has waited MAX_WAIT cycles
// gets a one-cycle write slot, and the burst pauses for that cycle.
// Optional build macro: VGA_FB_ARB_STATS_EN adds the stall_cnt output
// (count of cycles with wr_valid && !wr_ready, saturating).
module vga_fb_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 3,
    parameter int H_PIX    = 10,
    parameter int V_LINES  = 6,
    parameter int MAX_WAIT = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       line_start,
    input  logic [$clog2(V_LINES)-1:0] line_idx,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       lb_we,
    output logic [$clog2(H_PIX)-1:0]   lb_addr,
    output logic [DATA_W-1:0]          lb_data,
    output logic                       fetch_busy,
    output logic                       underrun,
`ifdef VGA_FB_ARB_STATS_EN
    output logic                       oob_err,
    output logic [15:0]                stall_cnt
`else
    output logic                       oob_err
`endif
);

    localparam int COL_W    = $clog2(H_PIX);
    localparam int WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam int FB_WORDS = H_PIX * V_LINES;

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   base;
    logic [COL_W-1:0]    col;
    logic [WAIT_W-1:0]   wait_cnt;

    logic                in_fetch;
    logic                slot;
    logic                rd_issue;
    logic                wr_fire;
    logic                wr_oob;
    logic [ADDR_W-1:0]   new_base;

    assign in_fetch   = (state == FETCH);
    assign fetch_busy = in_fetch;

    // The write slot is a burst cycle reserved for a writer that has waited long enough.
    assign slot       = in_fetch && (wait_cnt == WAIT_W'(MAX_WAIT));

    // Idle: writer wins unless a fetch is starting. Burst: writer only gets the slot.
    // Held low during reset so nothing is accepted while the block is being cleared.
    assign wr_ready   = !reset && (in_fetch ? slot : !line_start);
    assign wr_fire    = wr_valid && wr_ready;
    assign wr_oob     = 32'(wr_addr) >= FB_WORDS;

    // Every burst cycle except the write slot issues one read.
    assign rd_issue   = in_fetch && !slot;

    assign new_base   = ADDR_W'(line_idx) * ADDR_W'(H_PIX);

    // Line-buffer data is the RAM output, presented only while the strobe is high.
    assign lb_data    = lb_we ? mem_rdata : '0;

    // RAM port mux: accepted in-range write, else burst read, else idle.
    // NOTE: every output gets a default first so this block never infers a latch.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (wr_fire && !wr_oob) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end else if (rd_issue) begin
            mem_en    = 1'b1;
            mem_addr  = base + ADDR_W'(col);
        end
    end

    // Fetch FSM with its registered outputs: burst column, writer wait count,
    // line-buffer strobe/column, sticky underrun and the out-of-range pulse.
    // NOTE: sequential state uses non-blocking assignments only, so every register
    // here sees the pre-edge value of every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            base     <= '0;
            col      <= '0;
            wait_cnt <= '0;
            underrun <= 1'b0;
            lb_we    <= 1'b0;
            lb_addr  <= '0;
            oob_err  <= 1'b0;
        end else begin
            // Line buffer trails the read issue by one cycle, matching RAM latency.
            lb_we   <= rd_issue;
            lb_addr <= rd_issue ? col : '0;
            oob_err <= wr_fire && wr_oob;

            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (line_start) begin
                        state <= FETCH;
                        base  <= new_base;
                        col   <= '0;
                    end
                end

                FETCH: begin
                    // A writer that keeps asking accumulates wait; a slot or a
                    // withdrawn request starts the count over.
                    if (slot || !wr_valid) begin
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end

                    if (line_start) begin
                        // Timing generator wants the next line before this one
                        // finished: drop the rest and restart.
                        underrun <= 1'b1;
                        base     <= new_base;
                        col      <= '0;
                    end else if (rd_issue) begin
                        if (col == COL_W'(H_PIX - 1)) begin
                            state <= IDLE;
                            col   <= '0;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef VGA_FB_ARB_STATS_EN
    // Saturating count of cycles in which the writer was held off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (wr_valid && !wr_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Testbench for vga_fb_arbiter: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of line fetches and writes.
module tb_vga_fb_arbiter;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 3;
    localparam int H_PIX    = 10;
    localparam int V_LINES  = 6;
    localparam int MAX_WAIT = 8;
    localparam int FB_WORDS = H_PIX * V_LINES;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       line_start;
    logic [$clog2(V_LINES)-1:0] line_idx;
    logic                       wr_valid;
    logic                       wr_ready;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic                       mem_en;
    logic                       mem_we;
    logic [ADDR_W-1:0]          mem_addr;
    logic [DATA_W-1:0]          mem_wdata;
    logic [DATA_W-1:0]          mem_rdata;
    logic                       lb_we;
    logic [$clog2(H_PIX)-1:0]   lb_addr;
    logic [DATA_W-1:0]          lb_data;
    logic                       fetch_busy;
    logic                       underrun;
    logic                       oob_err;
`ifdef VGA_FB_ARB_STATS_EN
    logic [15:0]                stall_cnt;
`endif

    vga_fb_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .H_PIX(H_PIX),
        .V_LINES(V_LINES), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .reset(reset), .line_start(line_start), .line_idx(line_idx),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data),
        .fetch_busy(fetch_busy), .underrun(underrun),
`ifdef VGA_FB_ARB_STATS_EN
        .oob_err(oob_err), .stall_cnt(stall_cnt)
`else
        .oob_err(oob_err)
`endif
    );

    always #5 clk = ~clk;

    // Framebuffer RAM environment: one access per cycle, read data one cycle later.
    logic [DATA_W-1:0] fb [FB_WORDS];
    always @(posedge clk) begin
        if (mem_en && (int'(mem_addr) < FB_WORDS)) begin
            if (mem_we) fb[int'(mem_addr)] <= mem_wdata;
            else        mem_rdata <= fb[int'(mem_addr)];
        end
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a burst is a queue of addresses still to be read.
    int  q[$];
    int  cur_base;
    int  waitc;
    int  shadow [FB_WORDS];
    bit  e_lb_we;
    int  e_lb_addr;
    int  e_lb_data;
    bit  e_under;
    bit  e_oob;
    int  e_stall;
    bit  last_fire;

    task automatic model_reset();
        q.delete();
        cur_base  = 0;
        waitc     = 0;
        e_lb_we   = 0;
        e_lb_addr = 0;
        e_lb_data = 0;
        e_under   = 0;
        e_oob     = 0;
        e_stall   = 0;
        last_fire = 0;
    endtask

    // One clock cycle: check outputs mid-cycle against the model, then advance it.
    task automatic step();
        bit fetching, slot, e_ready, fire, oob, e_en, e_we, issued;
        int e_addr, e_wd;
        @(negedge clk);
        fetching = (q.size() != 0);
        slot     = fetching && (waitc == MAX_WAIT);
        e_ready  = fetching ? slot : !line_start;
        fire     = wr_valid && e_ready;
        oob      = int'(wr_addr) >= FB_WORDS;
        e_en = 0; e_we = 0; e_addr = 0; e_wd = 0;
        if (fire && !oob) begin
            e_en = 1; e_we = 1; e_addr = int'(wr_addr); e_wd = int'(wr_data);
        end else if (fetching && !slot) begin
            e_en = 1; e_addr = q[0];
        end
        check("wr_ready",   32'(wr_ready),   32'(e_ready));
        check("mem_en",     32'(mem_en),     32'(e_en));
        check("mem_we",     32'(mem_we),     32'(e_we));
        check("mem_addr",   32'(mem_addr),   32'(e_addr));
        check("mem_wdata",  32'(mem_wdata),  32'(e_wd));
        check("fetch_busy", 32'(fetch_busy), 32'(fetching));
        check("lb_we",      32'(lb_we),      32'(e_lb_we));
        check("lb_addr",    32'(lb_addr),    32'(e_lb_addr));
        check("lb_data",    32'(lb_data),    32'(e_lb_we ? e_lb_data : 0));
        check("underrun",   32'(underrun),   32'(e_under));
        check("oob_err",    32'(oob_err),    32'(e_oob));
`ifdef VGA_FB_ARB_STATS_EN
        check("stall_cnt",  32'(stall_cnt),  32'(e_stall));
`endif
        // Advance the model to the state after the coming edge.
        issued = fetching && !slot;
        if (issued) begin
            e_lb_we   = 1;
            e_lb_addr = q[0] - cur_base;
            e_lb_data = shadow[q[0]];
            void'(q.pop_front());
        end else begin
            e_lb_we   = 0;
            e_lb_addr = 0;
            e_lb_data = 0;
        end
        if (fire && !oob) shadow[int'(wr_addr)] = int'(wr_data);
        e_oob = fire && oob;
        if (wr_valid && !e_ready && e_stall < 65535) e_stall++;
        if (fetching && wr_valid && !slot) waitc++;
        else                               waitc = 0;
        if (line_start) begin
            if (fetching) e_under = 1;
            q.delete();
            cur_base = int'(line_idx) * H_PIX;
            for (int c = 0; c < H_PIX; c++) q.push_back(cur_base + c);
        end
        last_fire = fire;
        @(posedge clk);
        #1;
    endtask

    // While reset is held every output must be zero, even with a request pending.
    task automatic check_reset_outputs();
        check("rst_wr_ready",   32'(wr_ready),   32'd0);
        check("rst_mem_en",     32'(mem_en),     32'd0);
        check("rst_mem_we",     32'(mem_we),     32'd0);
        check("rst_mem_addr",   32'(mem_addr),   32'd0);
        check("rst_mem_wdata",  32'(mem_wdata),  32'd0);
        check("rst_lb_we",      32'(lb_we),      32'd0);
        check("rst_lb_addr",    32'(lb_addr),    32'd0);
        check("rst_lb_data",    32'(lb_data),    32'd0);
        check("rst_fetch_busy", 32'(fetch_busy), 32'd0);
        check("rst_underrun",   32'(underrun),   32'd0);
        check("rst_oob_err",    32'(oob_err),    32'd0);
`ifdef VGA_FB_ARB_STATS_EN
        check("rst_stall_cnt",  32'(stall_cnt),  32'd0);
`endif
    endtask

    task automatic start_line(input int idx);
        line_start = 1'b1;
        line_idx   = ($clog2(V_LINES))'(idx);
        step();
        line_start = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        line_start = 1'b0;
        line_idx   = '0;
        wr_valid   = 1'b1;
        wr_addr    = 12'd3;
        wr_data    = 3'd5;
        for (int i = 0; i < FB_WORDS; i++) begin
            shadow[i] = int'($urandom_range(0, 7));
            fb[i]     = DATA_W'(shadow[i]);
        end
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        wr_valid = 1'b0;
        reset    = 1'b0;

        // 1: fetch of line 2 -> reads 20..29, line buffer one cycle behind
        start_line(2);
        repeat (11) step();

        // 2: idle write then readback through a fetch of line 0
        wr_valid = 1'b1; wr_addr = 12'd5; wr_data = 3'b100;
        step();
        wr_valid = 1'b0;
        step();
        start_line(0);
        repeat (11) step();

        // 3: writer held from burst start -> slot after MAX_WAIT stalls
        start_line(0);
        wr_valid = 1'b1; wr_addr = 12'd7; wr_data = 3'b010;
        for (int i = 0; i < 14; i++) begin
            step();
            if (last_fire) wr_valid = 1'b0;
        end

        // 4: line 1 aborted by line 3 at fetch cycle 4 -> underrun, restart at 30
        start_line(1);
        repeat (3) step();
        start_line(3);
        repeat (12) step();

        // 5: out-of-range write is accepted, dropped and flagged
        wr_valid = 1'b1; wr_addr = 12'd60; wr_data = 3'b111;
        step();
        wr_valid = 1'b0;
        repeat (2) step();

        // 6: reset in the middle of a burst
        start_line(4);
        repeat (4) step();
        wr_valid = 1'b1;
        reset    = 1'b1;
        #2;
        check_reset_outputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        wr_valid = 1'b0;
        reset    = 1'b0;
        repeat (4) step();

        // Random traffic: writer holds each request until accepted
        for (int i = 0; i < 800; i++) begin
            if (!wr_valid || last_fire) begin
                wr_valid = ($urandom_range(0, 2) != 0);
                wr_addr  = ADDR_W'($urandom_range(0, FB_WORDS + 5));
                wr_data  = DATA_W'($urandom_range(0, 7));
            end
            if (q.size() == 0) line_start = ($urandom_range(0, 7) == 0);
            else               line_start = ($urandom_range(0, 39) == 0);
            line_idx = ($clog2(V_LINES))'($urandom_range(0, V_LINES - 1));
            step();
        end
        line_start = 1'b0;
        wr_valid   = 1'b0;
        repeat (15) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
